// File: rtl/sequence_checker_if.sv
// Bundle of strobes and status outputs between the key generator, the player
// input path, the game controller and the checker.
interface sequence_checker_if #(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4
);
    logic                        transmit;
    logic [DIGITS*DIGIT_W-1:0]   sequence_key;
    logic [DIGIT_W-1:0]          digit_in;
    logic                        digit_valid;
    logic                        tick;
    logic                        busy;
    logic [DIGITS-1:0]           progress;
    logic [7:0]                  time_left;
    logic                        pass;
    logic                        fail;

    modport master (
        output transmit, sequence_key, digit_in, digit_valid, tick,
        input  busy, progress, time_left, pass, fail
    );

    modport slave (
        input  transmit, sequence_key, digit_in, digit_valid, tick,
        output busy, progress, time_left, pass, fail
    );
endinterface

// File: rtl/sequence_checker.sv
// Checks player digit entries against a loaded key under a tick countdown and
// reports single-cycle pass/fail pulses plus progress and remaining time.
module sequence_checker #(
    parameter int DIGITS     = 4,
    parameter int DIGIT_W    = 4,
    parameter int TIME_LIMIT = 30
) (
    input  logic               clk,
    input  logic               rst,
    sequence_checker_if.slave  bus
);

    localparam int                IDX_W    = $clog2(DIGITS) + 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [7:0]        TL_INIT  = 8'(TIME_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_PASS,
        ST_FAIL
    } state_t;

    state_t               state;
    logic [DIGIT_W-1:0]   key_q [DIGITS];
    logic [IDX_W-1:0]     idx_q;
    logic                 busy_q;
    logic                 pass_q;
    logic                 fail_q;
    logic [DIGITS-1:0]    progress_q;
    logic [7:0]           time_left_q;

    logic [DIGIT_W-1:0]   cur_digit;
    logic [DIGITS-1:0]    idx_mask;
    logic                 load;
    logic                 digit_ok;
    logic                 digit_bad;
    logic                 expire;
    logic [7:0]           time_dec;

    // Mux the expected digit by loop compare so the index width stays decoupled
    // from the array range.
    always_comb begin
        cur_digit = '0;
        idx_mask  = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit   = key_q[i];
                idx_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        load      = bus.transmit && (state == ST_IDLE || state == ST_ARMED);
        digit_ok  = bus.digit_valid && (bus.digit_in == cur_digit);
        digit_bad = bus.digit_valid && (bus.digit_in != cur_digit);
        expire    = bus.tick && (time_left_q == 8'd1);
        time_dec  = time_left_q - 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                key_q[i] <= '0;
            end
            idx_q       <= '0;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            progress_q  <= '0;
            time_left_q <= '0;
        end else begin
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            if (load) begin
                // A reload in ARMED discards any digit or tick in the same cycle.
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    key_q[i] <= bus.sequence_key[i*DIGIT_W +: DIGIT_W];
                end
                idx_q       <= '0;
                progress_q  <= '0;
                time_left_q <= TL_INIT;
                busy_q      <= 1'b1;
                state       <= ST_ARMED;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end
                    ST_ARMED: begin
                        if (digit_ok) begin
                            progress_q <= progress_q | idx_mask;
                            if (idx_q == LAST_IDX) begin
                                state  <= ST_PASS;
                                busy_q <= 1'b0;
                                pass_q <= 1'b1;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                                if (bus.tick) begin
                                    time_left_q <= time_dec;
                                end
                                if (expire) begin
                                    state  <= ST_FAIL;
                                    busy_q <= 1'b0;
                                    fail_q <= 1'b1;
                                end
                            end
                        end else if (digit_bad) begin
                            state  <= ST_FAIL;
                            busy_q <= 1'b0;
                            fail_q <= 1'b1;
                        end else if (bus.tick) begin
                            time_left_q <= time_dec;
                            if (expire) begin
                                state  <= ST_FAIL;
                                busy_q <= 1'b0;
                                fail_q <= 1'b1;
                            end
                        end
                    end
                    ST_PASS, ST_FAIL: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.pass      = pass_q;
    assign bus.fail      = fail_q;
    assign bus.progress  = progress_q;
    assign bus.time_left = time_left_q;

    idx_in_range: assert property (@(posedge clk) disable iff (!rst)
        (state == ST_ARMED) |-> (idx_q <= LAST_IDX));

endmodule

// File: tb/tb_sequence_checker.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_sequence_checker;

    localparam int DIGITS     = 4;
    localparam int DIGIT_W    = 4;
    localparam int TIME_LIMIT = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sequence_checker_if #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W)) bus();

    sequence_checker #(
        .DIGITS(DIGITS),
        .DIGIT_W(DIGIT_W),
        .TIME_LIMIT(TIME_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: matched count, ticks remaining, and a one-cycle "cool" flag for
    // the pulse cycle during which a transmit is ignored.
    bit m_valid   = 1'b0;
    bit m_armed   = 1'b0;
    bit m_cool    = 1'b0;
    bit m_pass    = 1'b0;
    bit m_fail    = 1'b0;
    int m_matched = 0;
    int m_tl      = 0;
    int m_key [DIGITS];

    task automatic model_tick();
        m_tl = m_tl - 1;
        if (m_tl == 0) begin
            m_fail  = 1'b1;
            m_armed = 1'b0;
            m_cool  = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        logic [15:0] k;
        m_pass = 1'b0;
        m_fail = 1'b0;
        if (!rst) begin
            m_armed   = 1'b0;
            m_cool    = 1'b0;
            m_matched = 0;
            m_tl      = 0;
            for (int i = 0; i < DIGITS; i++) m_key[i] = 0;
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else if (bus.transmit) begin
            k = bus.sequence_key;
            for (int i = 0; i < DIGITS; i++) m_key[i] = int'((k >> (4 * i)) & 16'hF);
            m_matched = 0;
            m_tl      = TIME_LIMIT;
            m_armed   = 1'b1;
        end else if (m_armed) begin
            if (bus.digit_valid) begin
                if (int'(bus.digit_in) == m_key[m_matched]) begin
                    m_matched = m_matched + 1;
                    if (m_matched == DIGITS) begin
                        m_pass  = 1'b1;
                        m_armed = 1'b0;
                        m_cool  = 1'b1;
                    end else if (bus.tick) begin
                        model_tick();
                    end
                end else begin
                    m_fail  = 1'b1;
                    m_armed = 1'b0;
                    m_cool  = 1'b1;
                end
            end else if (bus.tick) begin
                model_tick();
            end
        end
        m_valid = 1'b1;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        cmp(name, act, exp);
    endtask

    always @(negedge clk) begin
        logic [DIGITS-1:0] exp_prog;
        if (m_valid) begin
            exp_prog = DIGITS'((1 << m_matched) - 1);
            vectors++;
            cmp("model_busy",      32'(bus.busy),      32'(m_armed));
            cmp("model_progress",  32'(bus.progress),  32'(exp_prog));
            cmp("model_time_left", 32'(bus.time_left), 32'(m_tl));
            cmp("model_pass",      32'(bus.pass),      32'(m_pass));
            cmp("model_fail",      32'(bus.fail),      32'(m_fail));
        end
    end

    task automatic step(input bit r, input bit tr, input logic [15:0] k,
                        input bit dv, input logic [3:0] d, input bit tk);
        rst              = r;
        bus.transmit     = tr;
        bus.sequence_key = k;
        bus.digit_valid  = dv;
        bus.digit_in     = d;
        bus.tick         = tk;
        @(negedge clk);
    endtask

    task automatic digit(input logic [3:0] d, input bit tk);
        step(1'b1, 1'b0, 16'h0, 1'b1, d, tk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        logic [15:0] rk;
        logic [3:0]  rd;
        bit          rr, rt, rv, rtk;

        bus.transmit     = 1'b0;
        bus.sequence_key = '0;
        bus.digit_valid  = 1'b0;
        bus.digit_in     = '0;
        bus.tick         = 1'b0;
        @(negedge clk);

        // Reset with activity on the inputs
        step(1'b0, 1'b1, 16'h4321, 1'b1, 4'h1, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_progress", 32'(bus.progress), 0);
        chk("rst_time_left", 32'(bus.time_left), 0);
        chk("rst_pass", 32'(bus.pass), 0);
        chk("rst_fail", 32'(bus.fail), 0);

        // Full match
        step(1'b1, 1'b1, 16'h4321, 1'b0, 4'h0, 1'b0);
        chk("load_busy", 32'(bus.busy), 1);
        chk("load_time_left", 32'(bus.time_left), 10);
        digit(4'h1, 1'b0); chk("match_p1", 32'(bus.progress), 32'h1);
        digit(4'h2, 1'b0); chk("match_p2", 32'(bus.progress), 32'h3);
        digit(4'h3, 1'b0); chk("match_p3", 32'(bus.progress), 32'h7);
        digit(4'h4, 1'b0);
        chk("match_pass", 32'(bus.pass), 1);
        chk("match_busy", 32'(bus.busy), 0);
        chk("match_p4", 32'(bus.progress), 32'hF);
        chk("match_time_left", 32'(bus.time_left), 10);
        idle(1);
        chk("match_pass_low", 32'(bus.pass), 0);
        chk("match_no_fail", 32'(bus.fail), 0);

        // Wrong digit
        step(1'b1, 1'b1, 16'h4321, 1'b0, 4'h0, 1'b0);
        digit(4'h1, 1'b0);
        digit(4'h7, 1'b0);
        chk("wrong_fail", 32'(bus.fail), 1);
        chk("wrong_progress", 32'(bus.progress), 32'h1);
        chk("wrong_busy", 32'(bus.busy), 0);
        digit(4'h2, 1'b0);
        chk("wrong_fail_low", 32'(bus.fail), 0);
        chk("wrong_ignored", 32'(bus.progress), 32'h1);

        // Timeout
        step(1'b1, 1'b1, 16'h4321, 1'b0, 4'h0, 1'b0);
        for (int t = 1; t < TIME_LIMIT; t++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 1'b1);
            chk("timeout_count", 32'(bus.time_left), 32'(TIME_LIMIT - t));
        end
        step(1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 1'b1);
        chk("timeout_fail", 32'(bus.fail), 1);
        chk("timeout_zero", 32'(bus.time_left), 0);
        idle(1);

        // Last digit together with the last tick
        step(1'b1, 1'b1, 16'h4321, 1'b0, 4'h0, 1'b0);
        for (int t = 1; t < TIME_LIMIT; t++) step(1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 1'b1);
        digit(4'h1, 1'b0);
        digit(4'h2, 1'b0);
        digit(4'h3, 1'b0);
        digit(4'h4, 1'b1);
        chk("simul_pass", 32'(bus.pass), 1);
        chk("simul_fail", 32'(bus.fail), 0);
        chk("simul_time_left", 32'(bus.time_left), 1);
        idle(1);

        // Reload overriding a digit, then mid-operation reset
        step(1'b1, 1'b1, 16'h4321, 1'b0, 4'h0, 1'b0);
        digit(4'h1, 1'b0);
        digit(4'h2, 1'b0);
        chk("reload_pre", 32'(bus.progress), 32'h3);
        step(1'b1, 1'b1, 16'h0000, 1'b1, 4'h3, 1'b0);
        chk("reload_progress", 32'(bus.progress), 0);
        chk("reload_time_left", 32'(bus.time_left), 10);
        digit(4'h0, 1'b0);
        digit(4'h0, 1'b0);
        chk("mid_pre", 32'(bus.progress), 32'h3);
        step(1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 1'b0);
        chk("mid_busy", 32'(bus.busy), 0);
        chk("mid_progress", 32'(bus.progress), 0);
        chk("mid_time_left", 32'(bus.time_left), 0);
        chk("mid_pass", 32'(bus.pass), 0);
        chk("mid_fail", 32'(bus.fail), 0);
        idle(1);
        chk("mid_after_pass", 32'(bus.pass), 0);
        chk("mid_after_fail", 32'(bus.fail), 0);

        // Randomized traffic, mostly-correct digits so passes occur
        for (int n = 0; n < 3000; n++) begin
            rr  = ($urandom_range(0, 199) != 0);
            rt  = ($urandom_range(0, 19) == 0);
            rk  = '0;
            for (int i = 0; i < DIGITS; i++) rk[4*i +: 4] = 4'($urandom_range(0, 3));
            rv  = 1'($urandom_range(0, 1));
            if (m_armed && m_matched < DIGITS && $urandom_range(0, 9) < 8)
                rd = 4'(m_key[m_matched]);
            else
                rd = 4'($urandom_range(0, 3));
            rtk = ($urandom_range(0, 4) == 0);
            step(rr, rt, rk, rv, rd, rtk);
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sequence_checker.md
# sequence_checker

Consumes the puzzle sequence produced by the sequence key generator and checks the player's digit entries against it, one digit at a time, under a countdown. Sits directly downstream of the generator: a `transmit` pulse loads `sequence_key` and arms the checker. The result is reported as one-cycle `pass` or `fail` pulses to the game controller, plus progress and remaining-time outputs for the display.

## Interface

**Parameters**
- `DIGITS`, default 4: number of digits in a sequence (1..8).
- `DIGIT_W`, default 4: bits per digit.
- `TIME_LIMIT`, default 30: countdown length in `tick` periods (1..255).

**Ports**
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `transmit`  in  1: one-cycle strobe; `sequence_key` is valid this cycle.
- `sequence_key`  in  DIGITS*DIGIT_W: digit 0 is in `[DIGIT_W-1:0]` and is entered first.
- `digit_in`  in  DIGIT_W: the player's digit.
- `digit_valid`  in  1: one-cycle strobe qualifying `digit_in`.
- `tick`  in  1: timebase strobe (e.g. 1 Hz), one cycle wide.
- `busy`  out  1: high while ARMED.
- `progress`  out  DIGITS: thermometer code; bit i is set once digit i has been matched.
- `time_left`  out  8: remaining ticks.
- `pass`  out  1: one-cycle pulse when the full sequence is matched.
- `fail`  out  1: one-cycle pulse on a wrong digit or on timeout.

## Operation

- **State machine:** IDLE, ARMED, PASS, FAIL.
- **Reset** (`rst`=0 at a clock edge), from any state:
  - state goes to IDLE.
  - `busy`=0, `progress`=0, `time_left`=0, `pass`=0, `fail`=0.
  - The stored key and digit index are cleared.
- **IDLE:**
  - `transmit`=1: latch `sequence_key`, index=0, `progress`=0, `time_left`=TIME_LIMIT, go to ARMED.
  - `digit_valid` and `tick` are ignored.
- **ARMED, per cycle, in priority order:**
  1. `transmit`=1: reload exactly as from IDLE and stay ARMED. Any `digit_valid` or `tick` in the same cycle is discarded.
  2. `digit_valid`=1 with `digit_in` equal to stored digit[index]: set `progress[index]` and increment index. If index was DIGITS-1, go to PASS.
  3. `digit_valid`=1 with a mismatch: go to FAIL. `progress` holds its value.
  4. `tick`=1 (decrement `time_left`):
     - Applied in the same cycle as a correct non-final digit.
     - Not applied if case 2 or 3 moved the state to PASS or FAIL.
     - If `time_left` was 1, it becomes 0 and the state goes to FAIL.
- **PASS:** `pass`=1 for this single cycle, then IDLE. `progress` stays all-ones; `time_left` is frozen.
- **FAIL:** `fail`=1 for this single cycle, then IDLE. `progress` and `time_left` are frozen.
- **Back in IDLE:** `progress` and `time_left` keep their last values, for display, until the next `transmit` or reset.
- **`transmit` while in PASS or FAIL:** ignored. The controller must wait for IDLE.
- **Index:** internal counter of width clog2(DIGITS)+1. It never exceeds DIGITS-1 while ARMED.
- **Digit comparison:** full DIGIT_W-bit equality. No wildcard values.

## Timing

- All outputs are registered; there is no combinational input-to-output path.
- **Load:** `transmit` at cycle n gives `busy`=1 and `time_left`=TIME_LIMIT at n+1.
- **Digit:** `digit_valid` at cycle n updates `progress` at n+1.
- **Final correct digit:** `digit_valid` at n gives `pass`=1 and `busy`=0 at n+1, with `pass` low again at n+2.
- **Wrong digit:** `digit_valid` at n gives `fail`=1 at n+1.
- **Timeout:** the tick that takes `time_left` from 1 to 0 at cycle n gives `fail`=1 and `time_left`=0 at n+1.
- **Final correct digit and last tick in the same cycle:** `pass` wins and `time_left` stays at 1.
- **Back-to-back `digit_valid`** on consecutive cycles must be accepted. No input buffering is needed beyond that.
- **Reset mid-operation** takes effect at the same edge. No `pass` or `fail` pulse is emitted.

## Test plan

Defaults: DIGITS=4, DIGIT_W=4, TIME_LIMIT=10.

- **Reset values:** hold `rst`=0 for 2 cycles, with `transmit` and `digit_valid` toggling. Expect all outputs 0 and state IDLE.
- **Full match:** load key 16'h4321, then enter digits 1,2,3,4 on consecutive cycles.
  - `progress` steps 0001, 0011, 0111, 1111.
  - `pass` is high exactly one cycle after the digit 4 strobe.
  - `fail` never asserts and `time_left` stays 10.
- **Wrong digit:** load 16'h4321, enter 1 then 7.
  - `fail` pulses one cycle after the 7 strobe.
  - `progress` holds 0001; `busy` falls.
  - A following `digit_valid` is ignored.
- **Timeout:** load a key, issue 10 ticks and no digits.
  - `time_left` counts 10 down to 0.
  - `fail` pulses one cycle after the 10th tick.
- **Simultaneous events, part 1:** with `time_left`=1 and 3 digits matched, assert the last correct digit and `tick` in the same cycle. Expect `pass`=1, `fail`=0, `time_left`=1.
- **Simultaneous events, part 2:** in ARMED with `progress`=0011, assert `transmit` with new key 16'h0000 together with `digit_valid`. Expect `progress`=0000 and `time_left`=10.
- **Mid-operation reset:** after 2 digits matched, assert `rst`=0 for 1 cycle. Expect all outputs 0 at the next edge and no pulse.
